// File: rtl/bank_dist_pkg.sv
// Shared helpers and the default-configuration beat type for the bank distributor stream.
package bank_dist_pkg;

  localparam int DEF_CHANNEL_NUMBER    = 3;
  localparam int DEF_CHANNEL_BANDWIDTH = 128;
  localparam int DEF_BLOCK_DEPTH       = 480;

  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // Bank b takes the word that sits r positions behind it in the input batch.
  function automatic int rot_src_index(input int b, input int r, input int n);
    return (b + n - r) % n;
  endfunction

  localparam int DEF_ADDR_W = clog2_min1(DEF_BLOCK_DEPTH);

  typedef struct packed {
    logic [DEF_CHANNEL_NUMBER-1:0][DEF_CHANNEL_BANDWIDTH-1:0] data;
    logic [DEF_CHANNEL_NUMBER-1:0][DEF_ADDR_W-1:0]            addr;
    logic [DEF_CHANNEL_NUMBER-1:0]                            we;
  } bank_beat_t;

endpackage

// File: rtl/bank_dist_skid.sv
// Generic 2-entry valid/ready skid buffer carrying one beat of type T.
// Only compiled when BANK_DIST_SKID_EN is defined.
`ifdef BANK_DIST_SKID_EN
module bank_dist_skid #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_beat,
  output logic out_valid,
  input  logic out_ready,
  output T     out_beat
);

  logic skid_valid;
  T     skid_beat;

  assign in_ready = !skid_valid;

  // The output slot refills from the skid entry first so ordering is kept;
  // a beat arriving while the output is stalled parks in the skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
    end else if (out_ready || !out_valid) begin
      if (skid_valid) begin
        out_beat   <= skid_beat;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_beat <= in_beat;
      end
    end else if (in_valid) begin
      skid_beat  <= in_beat;
      skid_valid <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/bank_distributor_stream.sv
// Registered, handshaked bank distributor: rotates a batch of words across BRAM banks.
// Define BANK_DIST_SKID_EN to place a 2-entry skid buffer behind the rotation stage.
module bank_distributor_stream
  import bank_dist_pkg::*;
#(
  parameter int CHANNEL_NUMBER    = 3,
  parameter int CHANNEL_BANDWIDTH = 128,
  parameter int BLOCK_DEPTH       = 480,
  parameter int AUTO_ADDR         = 0,
  localparam int ADDR_W           = clog2_min1(BLOCK_DEPTH)
) (
  input  logic                                             I_clk_in,
  input  logic                                             I_rst_n_in,
  input  logic                                             I_valid_in,
  output logic                                             O_ready_out,
  input  logic                                             I_sol_in,
  input  logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0] I_data_in,
  input  logic [ADDR_W-1:0]                                I_address_in,
  output logic                                             O_valid_out,
  input  logic                                             I_ready_in,
  output logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0] O_data_out,
  output logic [CHANNEL_NUMBER-1:0][ADDR_W-1:0]            O_address_out,
  output logic [CHANNEL_NUMBER-1:0]                        O_we_out,
  output logic                                             O_overrun_out
);

  localparam int R_W = clog2_min1(CHANNEL_NUMBER);
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(BLOCK_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_G  = ADDR_W'(BLOCK_DEPTH - 1);

  typedef struct packed {
    logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0] data;
    logic [CHANNEL_NUMBER-1:0][ADDR_W-1:0]            addr;
    logic [CHANNEL_NUMBER-1:0]                        we;
  } beat_t;

  logic              ready_en;
  logic [ADDR_W-1:0] beat_cnt;
  logic [ADDR_W-1:0] g;
  logic [R_W-1:0]    r;
  logic [R_W-1:0]    src;
  logic              in_range;
  logic              accept;
  logic              overrun;
  beat_t             rot_beat;
  beat_t             out_beat;
  logic              out_valid;

  // Input stays closed until the first clock after reset release.
  always_ff @(posedge I_clk_in or negedge I_rst_n_in) begin
    if (!I_rst_n_in) ready_en <= 1'b0;
    else             ready_en <= 1'b1;
  end

  always_comb begin
    g = I_address_in;
    if (AUTO_ADDR != 0) g = I_sol_in ? '0 : beat_cnt;
    in_range = ({1'b0, g} < DEPTH_V);
    r        = R_W'(g % CHANNEL_NUMBER);
  end

  always_comb begin
    rot_beat = '0;
    src      = '0;
    for (int b = 0; b < CHANNEL_NUMBER; b++) begin
      src              = R_W'(rot_src_index(b, int'(r), CHANNEL_NUMBER));
      rot_beat.data[b] = I_data_in[src];
      rot_beat.addr[b] = g;
    end
    rot_beat.we = in_range ? '1 : '0;
  end

  assign accept = I_valid_in && O_ready_out;

  // Out-of-range addresses also restart the counter so auto mode never leaves the bank.
  always_ff @(posedge I_clk_in or negedge I_rst_n_in) begin
    if (!I_rst_n_in) begin
      beat_cnt <= '0;
      overrun  <= 1'b0;
    end else if (accept) begin
      beat_cnt <= (g >= LAST_G) ? '0 : g + 1'b1;
      if (!in_range) overrun <= 1'b1;
    end
  end

`ifdef BANK_DIST_SKID_EN
  logic skid_in_ready;

  bank_dist_skid #(
    .T(beat_t)
  ) u_skid (
    .clk       (I_clk_in),
    .rst_n     (I_rst_n_in),
    .in_valid  (accept),
    .in_ready  (skid_in_ready),
    .in_beat   (rot_beat),
    .out_valid (out_valid),
    .out_ready (I_ready_in),
    .out_beat  (out_beat)
  );

  assign O_ready_out = ready_en && skid_in_ready;
`else
  always_ff @(posedge I_clk_in or negedge I_rst_n_in) begin
    if (!I_rst_n_in) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_beat  <= rot_beat;
    end else if (I_ready_in) begin
      out_valid <= 1'b0;
    end
  end

  assign O_ready_out = ready_en && (!out_valid || I_ready_in);
`endif

  assign O_valid_out   = out_valid;
  assign O_data_out    = out_beat.data;
  assign O_address_out = out_beat.addr;
  assign O_we_out      = out_valid ? out_beat.we : '0;
  assign O_overrun_out = overrun;

endmodule
